input_fifo_ctrl: RTL and testbench

Read-side controller for the 16-bit input FIFO of the Chebyshev function-unit datapath. It drains the FIFO with its one-cycle read latency and groups words into fixed-length frames (sample plus operands). It presents them to the downstream unit over a valid/ready stream with a last-word flag. It also counts completed frames and flags a mid-frame underrun timeout.

---
 rtl/input_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_input_fifo_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_fifo_ctrl.sv
// Read-side controller for the datapath input FIFO: drains the FIFO (1-cycle read latency),
// tags words into FRAME_LEN-word frames and presents them on a valid/ready stream with a
// last flag. Also counts completed frames and flags a mid-frame underrun timeout.
module input_fifo_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              err_timeout
);

    localparam int unsigned WidxW = $clog2(FRAME_LEN);
    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
    localparam logic [WidxW-1:0] WidxLast = WidxW'(FRAME_LEN - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);
    localparam logic [TmoW-1:0]  TmoMax   = TmoW'(TIMEOUT);

    typedef enum logic {StIdle, StFetch} state_e;

    state_e            state_q;
    logic [WidxW-1:0]  widx_q;
    logic              in_flight_q;
    logic              flight_last_q;
    logic [DATA_W:0]   buf_q [3];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [1:0]        occ_q, occ_d;
    logic [15:0]       frame_cnt_q;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              err_q, err_d;

    logic              credit;
    logic              push, pop;
    logic [DATA_W:0]   head;

    // Read is allowed only while the buffer can still absorb every word already requested.
    assign credit     = ({1'b0, occ_q} + {2'b00, in_flight_q}) < 3'd3;
    assign fifo_rd_en = ~srst & ~fifo_empty & credit & ((state_q == StFetch) | enable);

    assign push    = in_flight_q;
    assign head    = buf_q[rd_ptr_q];
    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? head[DATA_W-1:0] : '0;
    assign m_last  = m_valid & head[DATA_W];

    assign busy        = (state_q == StFetch) | m_valid | in_flight_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_timeout = err_q;

    // Frame fetch FSM; widx counts words read within the current frame.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q       <= StIdle;
            widx_q        <= '0;
            in_flight_q   <= 1'b0;
            flight_last_q <= 1'b0;
        end else begin
            in_flight_q <= fifo_rd_en;
            if (fifo_rd_en) begin
                flight_last_q <= (widx_q == WidxLast);
                if (widx_q == WidxLast) begin
                    state_q <= StIdle;
                    widx_q  <= '0;
                end else begin
                    state_q <= StFetch;
                    widx_q  <= widx_q + WidxW'(1);
                end
            end
        end
    end

    // Occupancy next state; simultaneous push and pop cancel out.
    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Three-entry output buffer; each entry holds the word plus its last tag.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= {flight_last_q, fifo_dout};
                wr_ptr_q        <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            end
            occ_q <= occ_d;
        end
    end

    // Underrun timer: counts consecutive empty cycles inside a frame, saturates at TIMEOUT.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        if ((state_q == StIdle) || fifo_rd_en) begin
            tmo_cnt_d = '0;
        end else if (fifo_empty) begin
            if (tmo_cnt_q == TmoLast) err_d = 1'b1;
            if (tmo_cnt_q != TmoMax) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end

    // Frame counter and sticky timeout flag.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            frame_cnt_q <= 16'd0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (pop && head[DATA_W]) frame_cnt_q <= frame_cnt_q + 16'd1;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_input_fifo_ctrl.sv
// Self-checking bench for input_fifo_ctrl: behavioural FIFO with 1-cycle read latency,
// scoreboard of expected stream words, and a negedge monitor comparing every transfer.
module tb_input_fifo_ctrl;

    localparam int DW  = 16;
    localparam int FL  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          err_timeout;

    input_fifo_ctrl #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .enable      (enable),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO storage and reference state.
    logic [DW-1:0] mem [0:8191];
    int            wr_idx = 0;
    int            rd_idx = 0;
    int            reads_total = 0;
    int            empty_run = 0;
    logic          model_err = 1'b0;
    logic [DW:0]   exp_q [$];
    int            n_written = 0;
    int            model_frames = 0;
    int            checks = 0;
    int            errors = 0;

    assign fifo_empty = (rd_idx == wr_idx);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // FIFO read port plus underrun reference: a frame is open whenever the number of words
    // read since reset is not a multiple of the frame length.
    always @(posedge clk or posedge srst) begin
        if (srst) begin
            rd_idx      <= wr_idx;
            fifo_dout   <= '0;
            reads_total <= 0;
            empty_run   <= 0;
            model_err   <= 1'b0;
        end else if (fifo_rd_en) begin
            fifo_dout   <= mem[rd_idx % 8192];
            rd_idx      <= rd_idx + 1;
            reads_total <= reads_total + 1;
            empty_run   <= 0;
        end else if ((reads_total % FL) != 0 && fifo_empty) begin
            if (empty_run + 1 >= TMO) model_err <= 1'b1;
            empty_run <= empty_run + 1;
        end
    end

    // Monitor: scoreboard pops, frame count, sticky error and hold stability.
    initial begin
        logic          hold;
        logic [DW:0]   held;
        logic [DW:0]   e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (srst) begin
                model_frames = 0;
                hold = 1'b0;
            end else begin
                chk("frame_cnt", frame_cnt, 16'(model_frames));
                chk("err_timeout", err_timeout, model_err);
                if (fifo_rd_en) chk("rd_when_empty", fifo_empty, 0);
                if (hold && m_valid) chk("hold_stable", {m_last, m_data}, held);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer", {m_last, m_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_word", {m_last, m_data}, e);
                        if (e[DW]) model_frames++;
                    end
                end
                hold = m_valid & ~m_ready;
                held = {m_last, m_data};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_idx % 8192] = d;
        wr_idx++;
        exp_q.push_back({(n_written % FL) == (FL - 1), d});
        n_written++;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        srst    = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        n_written = 0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int t_rd, t_v, nx, first_x, last_x;
        tick();
        do_reset();

        // Back-to-back streaming of two frames.
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        enable = 1'b1;
        t_rd = -1; t_v = -1; nx = 0; first_x = -1; last_x = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fifo_rd_en && t_rd < 0) t_rd = k;
            if (m_valid && t_v < 0) t_v = k;
            if (m_valid && m_ready) begin
                nx++;
                if (first_x < 0) first_x = k;
                last_x = k;
            end
        end
        chk("first_rd_cycle", t_rd, 0);
        chk("latency", t_v - t_rd, 2);
        chk("xfer_count", nx, 8);
        chk("xfer_span", last_x - first_x, 7);
        chk("frame_cnt_t1", frame_cnt, 2);
        chk("busy_idle_t1", busy, 0);
        tick();

        // Backpressure: only three words may be fetched ahead.
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        enable = 1'b1;
        repeat (10) tick();
        chk("bp_reads", reads_total, 3);
        chk("bp_rd_en_low", fifo_rd_en, 0);
        m_ready = 1'b1;
        wait_drain(60);
        chk("bp_reads_all", reads_total, 8);

        // enable dropped mid-frame: frame still completes, next frame waits.
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(16'h100 + i));
        enable = 1'b1;
        for (int i = 0; i < 20 && reads_total < 2; i++) tick();
        enable = 1'b0;
        chk("en_drop_at", reads_total, 2);
        repeat (10) tick();
        chk("en_drop_reads", reads_total, 4);
        chk("en_drop_cnt", frame_cnt, 1);
        enable = 1'b1;
        wait_drain(60);
        chk("en_resume_reads", reads_total, 8);

        // Mid-frame underrun sets the sticky flag; the frame still completes later.
        do_reset();
        m_ready = 1'b1;
        enable  = 1'b1;
        push_word(16'hA001);
        push_word(16'hA002);
        repeat (25) tick();
        chk("timeout_set", err_timeout, 1);
        push_word(16'hA003);
        push_word(16'hA004);
        wait_drain(40);
        repeat (3) tick();
        chk("timeout_frame_cnt", frame_cnt, 1);
        chk("timeout_sticky", err_timeout, 1);
        enable = 1'b0;

        // Reset while the buffer holds two words: everything discarded.
        do_reset();
        enable = 1'b1;
        push_word(16'hB001);
        push_word(16'hB002);
        repeat (6) tick();
        chk("pre_rst_valid", m_valid, 1);
        do_reset();
        m_ready = 1'b1;
        enable  = 1'b1;
        repeat (8) tick();
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_busy", busy, 0);

        // Randomised traffic against the scoreboard.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            enable  = ($urandom % 4) != 0;
            m_ready = ($urandom % 3) != 0;
            if ($urandom % 2 == 1) push_word(DW'($urandom));
        end
        while (n_written % FL != 0) push_word(DW'($urandom));
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_drain(400);
        repeat (5) tick();
        chk("rand_busy", busy, 0);
        chk("rand_frames", frame_cnt, 16'(n_written / FL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
